// File: rtl/ap_txn_recorder_if.sv
// Bundle of the monitored ap_ctrl_hs taps, the record stream and the
// recorder status flags. The recorder itself uses the slave modport.
interface ap_txn_recorder_if #(
  parameter int TS_W  = 32,
  parameter int LAT_W = 16
);
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             finish;
  logic             rec_valid;
  logic             rec_ready;
  logic [15:0]      rec_id;
  logic [TS_W-1:0]  rec_start_ts;
  logic [LAT_W-1:0] rec_latency;
  logic [LAT_W-1:0] rec_interval;
  logic             rec_last;
  logic [15:0]      dropped_cnt;
  logic             sq_overflow;
  logic             orphan_done;
  logic             drained;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    input  rec_valid, rec_id, rec_start_ts, rec_latency, rec_interval,
           rec_last, dropped_cnt, sq_overflow, orphan_done, drained
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready,
    output rec_valid, rec_id, rec_start_ts, rec_latency, rec_interval,
           rec_last, dropped_cnt, sq_overflow, orphan_done, drained
  );
endinterface

// File: rtl/ap_txn_recorder.sv
// Transaction recorder for one ap_ctrl_hs module: pairs starts with dones,
// builds {id, start_ts, latency, interval} records and streams them out
// through a first-word-fall-through record FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal capture of start and done events
// ST_DRAIN | finish seen; starts ignored, outstanding dones still paired
// ST_DONE  | terminal until reset; late dones only flag orphan_done
module ap_txn_recorder #(
  parameter int TS_W     = 32,
  parameter int LAT_W    = 16,
  parameter int SQ_DEPTH = 4,
  parameter int DEPTH    = 8
) (
  input  logic              clock,
  input  logic              reset,
  ap_txn_recorder_if.slave  bus
);
  localparam int SQ_AW   = $clog2(SQ_DEPTH);
  localparam int FIFO_AW = $clog2(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [SQ_AW:0]   SQ_FULL_CNT   = (SQ_AW+1)'(SQ_DEPTH);
  localparam logic [FIFO_AW:0] FIFO_FULL_CNT = (FIFO_AW+1)'(DEPTH);

  // Modulo difference clamped to the field width.
  function automatic logic [LAT_W-1:0] sat_diff(input logic [TS_W-1:0] a,
                                                input logic [TS_W-1:0] b);
    logic [TS_W-1:0] d;
    d = a - b;
    if (|(d >> LAT_W)) return '1;
    return d[LAT_W-1:0];
  endfunction

  logic [TS_W-1:0]  ts_q;
  logic [1:0]       state_q, state_d;
  logic [15:0]      id_q;
  logic [TS_W-1:0]  prev_ts_q;
  logic [15:0]      dropped_q;
  logic             sq_ovf_q;
  logic             orphan_q;

  // Start queue: timestamp, precomputed interval and id per outstanding start.
  logic [TS_W-1:0]  sq_ts_q  [SQ_DEPTH];
  logic [LAT_W-1:0] sq_int_q [SQ_DEPTH];
  logic [15:0]      sq_id_q  [SQ_DEPTH];
  logic [SQ_AW-1:0] sq_wr_q, sq_rd_q;
  logic [SQ_AW:0]   sq_cnt_q;

  // Record FIFO.
  logic [15:0]        ff_id_q  [DEPTH];
  logic [TS_W-1:0]    ff_ts_q  [DEPTH];
  logic [LAT_W-1:0]   ff_lat_q [DEPTH];
  logic [LAT_W-1:0]   ff_int_q [DEPTH];
  logic [FIFO_AW-1:0] ff_wr_q, ff_rd_q;
  logic [FIFO_AW:0]   ff_cnt_q;

  logic raw_start, raw_done, start_ev, done_ev;
  logic sq_empty, sq_full, sq_push, sq_pop;
  logic pair_bypass, pair_ok;
  logic ff_full, ff_push, ff_pop, rec_drop;
  logic sq_ovf_set, orphan_set;
  logic             rec_valid;
  logic [LAT_W-1:0] start_int;
  logic [15:0]      new_id;
  logic [TS_W-1:0]  new_ts;
  logic [LAT_W-1:0] new_lat, new_int;

  assign raw_start = bus.ap_start & bus.ap_ready;
  assign raw_done  = bus.ap_done & bus.ap_continue;
  // finish blocks starts in the very cycle it is first seen
  assign start_ev  = raw_start & (state_q == ST_RUN) & ~bus.finish;
  assign done_ev   = raw_done & (state_q != ST_DONE);

  assign sq_empty = (sq_cnt_q == '0);
  assign sq_full  = (sq_cnt_q == SQ_FULL_CNT);

  // A done with an empty queue pairs directly with a same-cycle start.
  assign pair_bypass = done_ev & sq_empty & start_ev;
  assign sq_pop      = done_ev & ~sq_empty;
  assign pair_ok     = pair_bypass | sq_pop;
  assign sq_push     = start_ev & ~pair_bypass & (~sq_full | sq_pop);
  assign sq_ovf_set  = start_ev & sq_full & ~sq_pop;
  assign orphan_set  = raw_done & ((state_q == ST_DONE) | (sq_empty & ~start_ev));

  assign start_int = (id_q == 16'd0) ? '0 : sat_diff(ts_q, prev_ts_q);

  assign new_id  = pair_bypass ? id_q      : sq_id_q[sq_rd_q];
  assign new_ts  = pair_bypass ? ts_q      : sq_ts_q[sq_rd_q];
  assign new_int = pair_bypass ? start_int : sq_int_q[sq_rd_q];
  assign new_lat = pair_bypass ? '0        : sat_diff(ts_q, sq_ts_q[sq_rd_q]);

  assign rec_valid = (ff_cnt_q != '0);
  assign ff_full   = (ff_cnt_q == FIFO_FULL_CNT);
  assign ff_pop    = rec_valid & bus.rec_ready;
  assign ff_push   = pair_ok & (~ff_full | ff_pop);
  assign rec_drop  = pair_ok & ff_full & ~ff_pop;

  // Next-state logic for the run/drain/done sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.finish) state_d = ST_DRAIN;
      ST_DRAIN: if (sq_empty && !done_ev) state_d = ST_DONE;
      default:  state_d = ST_DONE;
    endcase
  end

  // Timestamp, FSM, id counter, sticky flags and drop counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q      <= '0;
      state_q   <= ST_RUN;
      id_q      <= '0;
      prev_ts_q <= '0;
      dropped_q <= '0;
      sq_ovf_q  <= 1'b0;
      orphan_q  <= 1'b0;
    end else begin
      ts_q    <= ts_q + 1'b1;
      state_q <= state_d;
      if (start_ev) begin
        id_q      <= id_q + 1'b1;
        prev_ts_q <= ts_q;
      end
      if (rec_drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 1'b1;
      if (sq_ovf_set) sq_ovf_q <= 1'b1;
      if (orphan_set) orphan_q <= 1'b1;
    end
  end

  // Start queue pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sq_wr_q  <= '0;
      sq_rd_q  <= '0;
      sq_cnt_q <= '0;
    end else begin
      if (sq_push) sq_wr_q <= sq_wr_q + 1'b1;
      if (sq_pop)  sq_rd_q <= sq_rd_q + 1'b1;
      case ({sq_push, sq_pop})
        2'b10:   sq_cnt_q <= sq_cnt_q + 1'b1;
        2'b01:   sq_cnt_q <= sq_cnt_q - 1'b1;
        default: sq_cnt_q <= sq_cnt_q;
      endcase
    end
  end

  // Start queue storage; contents are meaningless while the count is zero.
  always_ff @(posedge clock) begin
    if (sq_push) begin
      sq_ts_q[sq_wr_q]  <= ts_q;
      sq_int_q[sq_wr_q] <= start_int;
      sq_id_q[sq_wr_q]  <= id_q;
    end
  end

  // Record FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ff_wr_q  <= '0;
      ff_rd_q  <= '0;
      ff_cnt_q <= '0;
    end else begin
      if (ff_push) ff_wr_q <= ff_wr_q + 1'b1;
      if (ff_pop)  ff_rd_q <= ff_rd_q + 1'b1;
      case ({ff_push, ff_pop})
        2'b10:   ff_cnt_q <= ff_cnt_q + 1'b1;
        2'b01:   ff_cnt_q <= ff_cnt_q - 1'b1;
        default: ff_cnt_q <= ff_cnt_q;
      endcase
    end
  end

  // Record FIFO storage; a full-FIFO push with a pop overwrites the head being read out.
  always_ff @(posedge clock) begin
    if (ff_push) begin
      ff_id_q[ff_wr_q]  <= new_id;
      ff_ts_q[ff_wr_q]  <= new_ts;
      ff_lat_q[ff_wr_q] <= new_lat;
      ff_int_q[ff_wr_q] <= new_int;
    end
  end

  // Data fields are forced to zero when empty so stale storage never shows after reset.
  assign bus.rec_valid    = rec_valid;
  assign bus.rec_id       = rec_valid ? ff_id_q[ff_rd_q]  : '0;
  assign bus.rec_start_ts = rec_valid ? ff_ts_q[ff_rd_q]  : '0;
  assign bus.rec_latency  = rec_valid ? ff_lat_q[ff_rd_q] : '0;
  assign bus.rec_interval = rec_valid ? ff_int_q[ff_rd_q] : '0;
  assign bus.rec_last     = rec_valid & (state_q == ST_DONE) & (ff_cnt_q == (FIFO_AW+1)'(1));
  assign bus.dropped_cnt  = dropped_q;
  assign bus.sq_overflow  = sq_ovf_q;
  assign bus.orphan_done  = orphan_q;
  assign bus.drained      = (state_q == ST_DONE) & ~rec_valid;
endmodule

// File: tb/tb_ap_txn_recorder.sv
// Directed bench for ap_txn_recorder. Inputs change and outputs are sampled
// on the falling edge; loop index c is the ts value of the current cycle.
module tb_ap_txn_recorder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  ap_txn_recorder_if #(.TS_W(32), .LAT_W(16)) bus ();

  ap_txn_recorder #(
    .TS_W(32), .LAT_W(16), .SQ_DEPTH(4), .DEPTH(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int id, input int ts, input int lat, input int iv);
    check_eq({tag, ".valid"},    64'(bus.rec_valid),    64'd1);
    check_eq({tag, ".id"},       64'(bus.rec_id),       64'(id));
    check_eq({tag, ".start_ts"}, 64'(bus.rec_start_ts), 64'(ts));
    check_eq({tag, ".latency"},  64'(bus.rec_latency),  64'(lat));
    check_eq({tag, ".interval"}, 64'(bus.rec_interval), 64'(iv));
  endtask

  task automatic drv(input logic s, input logic d);
    bus.ap_start = s;
    bus.ap_ready = s;
    bus.ap_done  = d;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Leaves the bench at the sampling point of cycle 0 (ts = 0).
  task automatic do_reset();
    reset = 1'b1;
    drv(1'b0, 1'b0);
    bus.ap_continue = 1'b1;
    bus.finish      = 1'b0;
    bus.rec_ready   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check_eq("rst.valid",   64'(bus.rec_valid),   64'd0);
    check_eq("rst.id",      64'(bus.rec_id),      64'd0);
    check_eq("rst.dropped", 64'(bus.dropped_cnt), 64'd0);
    check_eq("rst.ovf",     64'(bus.sq_overflow), 64'd0);
    check_eq("rst.orphan",  64'(bus.orphan_done), 64'd0);
    check_eq("rst.drained", 64'(bus.drained),     64'd0);
    check_eq("rst.last",    64'(bus.rec_last),    64'd0);

    // Single transaction: start 3, done 10.
    bus.rec_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      drv(c == 3, c == 10);
      if (c == 10) check_eq("single.early", 64'(bus.rec_valid), 64'd0);
      if (c == 11) chk_rec("single", 0, 3, 7, 0);
      if (c == 12) check_eq("single.empty", 64'(bus.rec_valid), 64'd0);
      tick();
    end

    // Overlapped pipeline: starts 2,4,6; dones 9,11,13.
    do_reset();
    bus.rec_ready = 1'b1;
    for (int c = 0; c <= 15; c++) begin
      drv(c == 2 || c == 4 || c == 6, c == 9 || c == 11 || c == 13);
      if (c == 10) chk_rec("pipe0", 0, 2, 7, 0);
      if (c == 12) chk_rec("pipe1", 1, 4, 7, 2);
      if (c == 14) chk_rec("pipe2", 2, 6, 7, 2);
      if (c == 15) check_eq("pipe.empty", 64'(bus.rec_valid), 64'd0);
      tick();
    end

    // Backpressure: 10 transactions (start 2k+1, done 2k+2) into an 8-deep FIFO.
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      drv(c <= 19 && (c % 2) == 1, c >= 2 && c <= 20 && (c % 2) == 0);
      if (c == 5)  check_eq("bp.head_early", 64'(bus.rec_id), 64'd0);
      if (c == 21) begin
        check_eq("bp.dropped", 64'(bus.dropped_cnt), 64'd2);
        chk_rec("bp.stall", 0, 1, 1, 0);
      end
      if (c == 22) bus.rec_ready = 1'b1;
      if (c >= 22 && c <= 29)
        chk_rec($sformatf("bp.rec%0d", c - 22), c - 22, 2 * (c - 22) + 1, 1, (c == 22) ? 0 : 2);
      if (c == 30) check_eq("bp.empty", 64'(bus.rec_valid), 64'd0);
      tick();
    end

    // Boundaries: same-cycle pair, orphan done, start-queue overflow.
    do_reset();
    bus.rec_ready = 1'b1;
    for (int c = 0; c <= 19; c++) begin
      drv(c == 2 || (c >= 8 && c <= 12), c == 2 || c == 5 || (c >= 14 && c <= 17));
      if (c == 3)  chk_rec("same", 0, 2, 0, 0);
      if (c == 5)  check_eq("orphan.before", 64'(bus.orphan_done), 64'd0);
      if (c == 6) begin
        check_eq("orphan.set",    64'(bus.orphan_done), 64'd1);
        check_eq("orphan.no_rec", 64'(bus.rec_valid),   64'd0);
      end
      if (c == 12) check_eq("ovf.before", 64'(bus.sq_overflow), 64'd0);
      if (c == 13) check_eq("ovf.set",    64'(bus.sq_overflow), 64'd1);
      if (c == 15) chk_rec("ovf.rec1", 1, 8, 6, 6);
      if (c == 16) chk_rec("ovf.rec2", 2, 9, 6, 1);
      if (c == 18) chk_rec("ovf.rec4", 4, 11, 6, 1);
      if (c == 19) check_eq("ovf.empty", 64'(bus.rec_valid), 64'd0);
      tick();
    end

    // Latency saturation: start 1, done 70001.
    do_reset();
    bus.rec_ready = 1'b1;
    for (int c = 0; c <= 70002; c++) begin
      drv(c == 1, c == 70001);
      if (c == 70002) chk_rec("sat", 0, 1, 65535, 0);
      tick();
    end

    // Finish drain: starts 1,2; finish from 4; ignored start 6; dones 7,8.
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      drv(c == 1 || c == 2 || c == 6, c == 7 || c == 8 || c == 12);
      if (c == 4) bus.finish = 1'b1;
      if (c == 9) begin
        check_eq("drain.last_early", 64'(bus.rec_last), 64'd0);
        check_eq("drain.not_done",   64'(bus.drained),  64'd0);
      end
      if (c == 10) begin
        chk_rec("drain.rec0", 0, 1, 6, 0);
        check_eq("drain.last0",   64'(bus.rec_last), 64'd0);
        check_eq("drain.pending", 64'(bus.drained),  64'd0);
        bus.rec_ready = 1'b1;
      end
      if (c == 11) begin
        chk_rec("drain.rec1", 1, 2, 6, 1);
        check_eq("drain.last1", 64'(bus.rec_last), 64'd1);
      end
      if (c == 12) begin
        check_eq("drain.empty",     64'(bus.rec_valid),   64'd0);
        check_eq("drain.drained",   64'(bus.drained),     64'd1);
        check_eq("drain.last_gone", 64'(bus.rec_last),    64'd0);
        check_eq("drain.no_orphan", 64'(bus.orphan_done), 64'd0);
      end
      if (c == 13) check_eq("drain.late_done", 64'(bus.orphan_done), 64'd1);
      tick();
    end

    // Async reset mid-transaction, asserted between clock edges.
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      drv(c == 2 || c == 7, c == 1 || c == 5);
      tick();
    end
    drv(1'b0, 1'b0);
    check_eq("arst.pre_valid",  64'(bus.rec_valid),   64'd1);
    check_eq("arst.pre_orphan", 64'(bus.orphan_done), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst.valid",  64'(bus.rec_valid),    64'd0);
    check_eq("arst.id",     64'(bus.rec_id),       64'd0);
    check_eq("arst.ts",     64'(bus.rec_start_ts), 64'd0);
    check_eq("arst.orphan", 64'(bus.orphan_done),  64'd0);
    do_reset();
    bus.rec_ready = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      drv(c == 3, c == 4);
      if (c == 5) chk_rec("arst.after", 0, 3, 1, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
